// File: rtl/bram_loader.sv
// Packs a little-endian byte stream into BRAM words, one write per DATA_WIDTH/8+1 cycles.
// s_ready is high only in LOAD; abort cancels a running load, reset drops it.
module bram_loader #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  abort,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   output logic                  s_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  ena,
   output logic                  wea,
   output logic [ADDR_WIDTH-1:0] addra,
   output logic [DATA_WIDTH-1:0] dia
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t                  state, state_nxt;
   logic [BW-1:0]           byte_idx;
   logic [ADDR_WIDTH:0]     word_cnt, word_lat, word_cnt_inc;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   word_reg, word_asm;
   logic                    last_byte;

   assign word_cnt_inc = word_cnt + (ADDR_WIDTH+1)'(1);
   assign last_byte    = (byte_idx == BW'(NB-1));

   always_comb begin
      word_asm = word_reg;
      word_asm[{byte_idx, 3'b000} +: 8] = s_data;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start)
               state_nxt = (word_count == '0) ? DONE : LOAD;
         end
         LOAD: begin
            if (abort)
               state_nxt = IDLE;
            else if (s_valid && last_byte)
               state_nxt = WRITE;
         end
         WRITE: begin
            if (abort)
               state_nxt = IDLE;
            else if (word_cnt_inc == word_lat)
               state_nxt = DONE;
            else
               state_nxt = LOAD;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         byte_idx <= '0;
         word_cnt <= '0;
         word_lat <= '0;
         addr     <= '0;
         word_reg <= '0;
         addra    <= '0;
         dia      <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start && word_count != '0) begin
                  addr     <= base_addr;
                  word_lat <= word_count;
                  byte_idx <= '0;
                  word_cnt <= '0;
               end
            end
            LOAD: begin
               // bytes arriving alongside abort are dropped with the partial word
               if (s_valid && !abort) begin
                  word_reg <= word_asm;
                  if (last_byte) begin
                     byte_idx <= '0;
                     addra    <= addr;
                     dia      <= word_asm;
                  end else begin
                     byte_idx <= byte_idx + BW'(1);
                  end
               end
            end
            WRITE: begin
               word_cnt <= word_cnt_inc;
               addr     <= addr + ADDR_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

   assign s_ready = (state == LOAD);
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign ena     = (state == WRITE);
   assign wea     = (state == WRITE);

endmodule

// File: tb/tb_bram_loader.sv
// Randomized bench for bram_loader: stream model in queues, expected writes from byte arithmetic.
module tb_bram_loader;

   localparam int AW = 9;
   localparam int DW = 32;
   localparam int NB = DW / 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start, abort, s_valid;
   logic [7:0]    s_data;
   logic [AW-1:0] base_addr;
   logic [AW:0]   word_count;
   logic          s_ready, busy, done, ena, wea;
   logic [AW-1:0] addra;
   logic [DW-1:0] dia;

   int errors = 0;
   int checks = 0;

   logic [7:0]    byte_q[$];
   logic [7:0]    pat[$];
   logic [AW-1:0] got_a[$], exp_a[$];
   logic [DW-1:0] got_d[$], exp_d[$];
   int            done_n, acc_n, cyc, start_cyc, done_cyc;
   bit            rnd_valid;

   bram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .word_count(word_count), .abort(abort), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .busy(busy), .done(done), .ena(ena), .wea(wea),
      .addra(addra), .dia(dia)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // byte source: present head of queue, optionally with random gaps
   always @(negedge clk) begin
      if (byte_q.size() > 0 && (!rnd_valid || $urandom_range(0, 1) == 1)) begin
         s_valid = 1'b1;
         s_data  = byte_q[0];
      end else begin
         s_valid = 1'b0;
         s_data  = 8'($urandom);
      end
   end

   // observer: handshakes, BRAM writes, done pulses, cycle stamps
   always @(posedge clk) begin
      if (s_valid && s_ready && byte_q.size() > 0) begin
         void'(byte_q.pop_front());
         acc_n++;
      end
      if (ena && wea) begin
         got_a.push_back(addra);
         got_d.push_back(dia);
      end
      if (start && !busy) start_cyc = cyc;
      if (done) begin
         done_n++;
         done_cyc = cyc;
      end
      cyc++;
   end

   task automatic begin_case();
      got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
      done_n = 0;
      acc_n  = 0;
   endtask

   task automatic build_expected(input logic [AW-1:0] base, input int nwords);
      for (int i = 0; i < nwords; i++) begin
         logic [DW-1:0] w;
         w = '0;
         for (int k = 0; k < NB; k++)
            w = w | (DW'(pat[i*NB+k]) << (8*k));
         exp_a.push_back(AW'((int'(base) + i) % (1 << AW)));
         exp_d.push_back(w);
      end
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check_eq({tag, "_nwr"}, 64'(got_a.size()), 64'(exp_a.size()));
      n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
      for (int i = 0; i < n; i++) begin
         check_eq($sformatf("%s_addr%0d", tag, i), 64'(got_a[i]), 64'(exp_a[i]));
         check_eq($sformatf("%s_data%0d", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
      end
   endtask

   task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] cnt);
      @(negedge clk);
      start      = 1'b1;
      base_addr  = base;
      word_count = cnt;
      @(negedge clk);
      start      = 1'b0;
      base_addr  = AW'($urandom);
      word_count = (AW+1)'($urandom);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < budget);
      if (busy) check_eq({tag, "_timeout"}, 64'(busy), 64'(0));
   endtask

   task automatic run_case(input string tag, input logic [AW-1:0] base, input int nwords,
                           input bit rv, input bit poke);
      begin_case();
      rnd_valid = rv;
      if (pat.size() == 0)
         for (int i = 0; i < nwords*NB; i++) pat.push_back(8'($urandom));
      build_expected(base, nwords);
      foreach (pat[i]) byte_q.push_back(pat[i]);
      do_start(base, (AW+1)'(nwords));
      if (poke) begin
         repeat (3) @(negedge clk);
         start      = 1'b1;
         base_addr  = ~base;
         word_count = (AW+1)'(7);
         @(negedge clk);
         start      = 1'b0;
      end
      wait_idle(tag, 300 + 20*nwords);
      compare_writes(tag);
      check_eq({tag, "_done"}, 64'(done_n), 64'(1));
      pat.delete();
      byte_q.delete();
   endtask

   initial begin
      logic [7:0] p37 [8];
      p37 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      reset_n    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      base_addr  = '0;
      word_count = '0;
      rnd_valid  = 1'b0;
      cyc        = 0;
      start_cyc  = 0;
      done_cyc   = 0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy",   64'(busy),    64'(0));
      check_eq("rst_sready", 64'(s_ready), 64'(0));
      check_eq("rst_done",   64'(done),    64'(0));
      check_eq("rst_ena",    64'(ena),     64'(0));
      check_eq("rst_addra",  64'(addra),   64'(0));
      check_eq("rst_dia",    64'(dia),     64'(0));
      reset_n = 1'b1;
      @(negedge clk);

      // fixed back-to-back load with known bytes
      foreach (p37[i]) pat.push_back(p37[i]);
      run_case("b2b", 9'h010, 2, 1'b0, 1'b0);
      check_eq("b2b_latency", 64'(done_cyc - start_cyc), 64'(11));
      check_eq("b2b_busy_after", 64'(busy), 64'(0));

      // address wrap at the top of the BRAM
      run_case("wrap", 9'h1FF, 2, 1'b0, 1'b0);
      check_eq("wrap_second", (got_a.size() > 1) ? 64'(got_a[1]) : 64'hDEAD, 64'(0));

      // zero-length request
      run_case("zero", 9'h055, 0, 1'b0, 1'b0);
      check_eq("zero_latency", 64'(done_cyc - start_cyc), 64'(1));

      // gappy stream plus a start pulse while busy
      run_case("gappy", 9'h020, 4, 1'b1, 1'b1);

      // abort after six bytes of a three-word load
      begin_case();
      rnd_valid = 1'b0;
      for (int i = 0; i < 3*NB; i++) pat.push_back(8'($urandom));
      build_expected(9'h040, 1);
      foreach (pat[i]) byte_q.push_back(pat[i]);
      do_start(9'h040, 3);
      begin
         int n;
         n = 0;
         while (acc_n < 6 && n < 100) begin
            @(negedge clk);
            n++;
         end
         check_eq("abort_reach6", 64'(acc_n >= 6), 64'(1));
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_eq("abort_idle", 64'(busy), 64'(0));
      byte_q.delete();
      pat.delete();
      repeat (5) @(negedge clk);
      compare_writes("abort");
      check_eq("abort_nodone", 64'(done_n), 64'(0));
      run_case("post_abort", 9'h100, 3, 1'b1, 1'b0);

      // asynchronous reset in the middle of a load
      begin_case();
      rnd_valid = 1'b0;
      for (int i = 0; i < 2*NB; i++) byte_q.push_back(8'($urandom));
      do_start(9'h0F0, 2);
      begin
         int n;
         n = 0;
         while (acc_n < 2 && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      #2 reset_n = 1'b0;
      #1;
      check_eq("arst_busy",   64'(busy),    64'(0));
      check_eq("arst_sready", 64'(s_ready), 64'(0));
      check_eq("arst_done",   64'(done),    64'(0));
      check_eq("arst_ena",    64'(ena),     64'(0));
      check_eq("arst_wea",    64'(wea),     64'(0));
      check_eq("arst_addra",  64'(addra),   64'(0));
      check_eq("arst_dia",    64'(dia),     64'(0));
      byte_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      check_eq("arst_nowrite", 64'(got_a.size()), 64'(0));
      check_eq("arst_nodone",  64'(done_n),       64'(0));
      run_case("post_rst", 9'h0F0, 2, 1'b0, 1'b0);

      // random loads
      for (int t = 0; t < 5; t++)
         run_case($sformatf("rand%0d", t), AW'($urandom), $urandom_range(1, 5),
                  1'($urandom_range(0, 1)), 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bram_loader.md
BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, BRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, BRAM word width; legal values are integer multiples of 8, minimum 8.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  load request, sampled in IDLE only.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first word address, latched on accepted start.
REQ-007 SHALL have port word_count  input  ADDR_WIDTH+1  number of words to load, latched on accepted start.
REQ-008 SHALL have port abort  input  1  synchronous cancel of a running load.
REQ-009 SHALL have port s_valid  input  1  byte-stream valid.
REQ-010 SHALL have port s_data  input  8  byte-stream data.
REQ-011 SHALL have port s_ready  output  1  byte-stream ready.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port ena  output  1  BRAM write-port enable.
REQ-015 SHALL have port wea  output  1  BRAM write enable.
REQ-016 SHALL have port addra  output  ADDR_WIDTH  BRAM write address.
REQ-017 SHALL have port dia  output  DATA_WIDTH  BRAM write data.

Function
REQ-018 SHALL implement an FSM with the states IDLE, LOAD, WRITE and DONE, entering IDLE on reset.
REQ-019 IDLE: start=1 with word_count!=0 SHALL latch base_addr and word_count, clear the byte index and word counter, and move to LOAD.
REQ-020 IDLE: start=1 with word_count==0 SHALL pulse done on the next cycle (via DONE) and perform no BRAM write.
REQ-021 start SHALL be ignored in all states other than IDLE.
REQ-022 LOAD: s_ready SHALL be 1, and a byte transfers when s_valid and s_ready are both 1.
REQ-023 Byte assembly SHALL be little-endian: byte index k is placed in the word register at bits [8k+7:8k], for k = 0..DATA_WIDTH/8-1.
REQ-024 A transfer at index DATA_WIDTH/8-1 SHALL move the FSM to WRITE and reset the byte index to 0.
REQ-025 WRITE: for exactly one cycle, ena=1, wea=1, addra=current address and dia=assembled word; s_ready SHALL be 0.
REQ-026 After WRITE, the word counter SHALL increment; if it equals the latched word_count the FSM SHALL go to DONE, otherwise to LOAD with the address incremented.
REQ-027 Address increment SHALL wrap modulo 2^ADDR_WIDTH (e.g. 511 -> 0 for ADDR_WIDTH=9).
REQ-028 DONE: done=1 for one cycle, then unconditionally IDLE.
REQ-029 abort=1 in LOAD or WRITE SHALL force IDLE on the next edge with no done pulse; a write already presented in that cycle completes; partial bytes are discarded.
REQ-030 abort SHALL take priority over all other transitions and SHALL be ignored in IDLE and DONE.
REQ-031 ena and wea SHALL be 0 outside WRITE; addra and dia hold their last value.
REQ-032 s_ready SHALL be 0 in IDLE, WRITE and DONE; s_valid without s_ready SHALL be ignored.
REQ-033 Throughput SHALL be one word per DATA_WIDTH/8+1 cycles with a continuously valid stream (5 cycles for 32 bits).
REQ-034 All outputs SHALL be registered or decoded only from the FSM state; there SHALL be no combinational path from an input to an output.

Reset
REQ-035 reset_n=0 SHALL immediately force IDLE with s_ready=0, busy=0, done=0, ena=0, wea=0, addra=0, dia=0, and the byte index, word counter and latched registers cleared.
REQ-036 Reset mid-load SHALL abandon the load with no done pulse and no further writes.

Verification
REQ-037 base_addr=0x010, word_count=2, bytes 11 22 33 44 55 66 77 88 streamed back-to-back -> writes 0x44332211@0x010 then 0x88776655@0x011, done pulse in cycle 11 after start, busy low afterwards.
REQ-038 base_addr=0x1FF, word_count=2 -> writes go to 0x1FF then 0x000.
REQ-039 word_count=0 -> done pulses once with no ena; start pulses asserted while busy -> ignored, write count unchanged.
REQ-040 s_valid toggled randomly during a 4-word load -> data and addresses identical to the back-to-back case; no byte is accepted while s_ready=0.
REQ-041 abort after 6 bytes of a 3-word load -> exactly 1 write, no done, IDLE next cycle; the next start loads correctly.
REQ-042 reset_n pulsed low mid-LOAD -> all outputs take their REQ-035 values asynchronously; no write after deassertion until a new start.
